// File: rtl/my_pkg.sv
// Shared state encoding and byte-enable constants for the data-memory bus adapter.
package my_pkg;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} mem_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering between the right-aligned LSU view and the word-aligned memory bus,
// plus detection of stores whose size does not fit their address offset.
module lane_align
    import my_pkg::*;
(
    input  logic [1:0]  i_st_offset,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    assign o_be    = i_be << i_st_offset;
    assign o_wdata = i_wdata << {i_st_offset, 3'b000};
    assign o_rdata = i_rdata >> {i_ld_offset, 3'b000};

    // Bytes can sit anywhere; halves need an even offset and words offset zero.
    always_comb begin
        case (i_be)
            BE_BYTE: o_misaligned = 1'b0;
            BE_HALF: o_misaligned = i_st_offset[0];
            BE_WORD: o_misaligned = (i_st_offset != 2'b00);
            default: o_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_adapter.sv
// Load/store port to a variable-latency data memory: req/gnt/rvalid handshake,
// byte-lane steering, timeout abort and a one-cycle err pulse for rejected requests.
module mem_bus_adapter
    import my_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic [31:0] read_address,
    input  logic [3:0]  write,
    input  logic [31:0] write_address,
    input  logic [31:0] wdata,
    output logic [31:0] DATA_in,
    output logic        busy,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    mem_state_t         r_state;
    mem_state_t         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_ld_offset;
    logic               r_mem_we;
    logic [3:0]         r_mem_be;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_data_in;
    logic               r_err;

    logic               w_load;
    logic               w_store;
    logic               w_timeout;
    logic               w_err_next;
    logic               w_accept_ld;
    logic               w_accept_st;
    logic               w_capture;
    logic [3:0]         w_be_steered;
    logic [31:0]        w_wdata_steered;
    logic [31:0]        w_rdata_aligned;
    logic               w_misaligned;

    lane_align u_lane_align (
        .i_st_offset  (write_address[1:0]),
        .i_be         (write),
        .i_wdata      (wdata),
        .i_ld_offset  (r_ld_offset),
        .i_rdata      (mem_rdata),
        .o_be         (w_be_steered),
        .o_wdata      (w_wdata_steered),
        .o_rdata      (w_rdata_aligned),
        .o_misaligned (w_misaligned)
    );

    assign w_load    = (read == 1'b1);
    assign w_store   = (write != 4'b0000);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Completion always takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_err_next   = 1'b0;
        w_accept_ld  = 1'b0;
        w_accept_st  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_store) begin
                    w_err_next = w_misaligned | w_load;
                    if (!w_misaligned) begin
                        w_next_state = WR_REQ;
                        w_accept_st  = 1'b1;
                    end
                end else if (w_load) begin
                    w_next_state = RD_REQ;
                    w_accept_ld  = 1'b1;
                end
            end
            RD_REQ: begin
                if (mem_gnt && mem_rvalid) begin
                    w_next_state = IDLE;
                    w_capture    = 1'b1;
                end else if (mem_gnt) begin
                    w_next_state = RD_DATA;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    w_next_state = IDLE;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            WR_REQ: begin
                if (mem_gnt) begin
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ld_offset <= 2'b00;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_data_in   <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err_next;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept_st) begin
                r_mem_addr  <= word_align(write_address);
                r_mem_we    <= 1'b1;
                r_mem_be    <= w_be_steered;
                r_mem_wdata <= w_wdata_steered;
            end
            // Load size is unknown here, so the whole word is fetched.
            if (w_accept_ld) begin
                r_mem_addr  <= word_align(read_address);
                r_mem_we    <= 1'b0;
                r_mem_be    <= BE_WORD;
                r_ld_offset <= read_address[1:0];
            end
            if (w_capture) begin
                r_data_in <= w_rdata_aligned;
            end
        end
    end

    assign mem_req   = (r_state == RD_REQ) || (r_state == WR_REQ);
    assign busy      = (r_state != IDLE);
    assign err       = r_err;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign DATA_in   = r_data_in;

endmodule
